// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Controls the IF stage of the 5-stage core. It merges three stall and redirect
//   sources into freeze / branch_taken / branch_address: ID hazard stalls,
//   EXE-resolved branches and data-memory wait states. It also drives the
//   pipeline flush and stall_all controls, keeps saturating performance counters,
//   and runs a watchdog that counts consecutive hazard stalls.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal fetch; hazard_detected_i may freeze the PC
//   MEM_W | data memory busy, whole pipeline held; a branch may be pending
//   REDIR | redirect issued, bubbles flushed for FLUSH_CYCLES cycles
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   hazard_detected_i              ID-stage data hazard
//   exe_branch_req_i/addr_i        taken branch resolved in EXE and its target
//   mem_busy_i                     data memory wait state
//   perf_clr_i                     clears the counters and stall_timeout_o
//   freeze_o, branch_taken_o,      IF-stage controls
//   branch_address_o
//   flush_o, stall_all_o           pipeline bubble and hold controls
//   state_o                        0 RUN, 1 MEM_WAIT, 2 REDIRECT
//   stall_count_o, branch_count_o  saturating event counters
//   stall_timeout_o                sticky hazard watchdog flag
module fetch_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_LIMIT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hazard_detected_i,
    input  logic              exe_branch_req_i,
    input  logic [ADDR_W-1:0] exe_branch_addr_i,
    input  logic              mem_busy_i,
    input  logic              perf_clr_i,
    output logic              freeze_o,
    output logic              branch_taken_o,
    output logic [ADDR_W-1:0] branch_address_o,
    output logic              flush_o,
    output logic              stall_all_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_count_o,
    output logic [CNT_W-1:0]  branch_count_o,
    output logic              stall_timeout_o
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    localparam int         WD_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    logic [1:0]        state_q, state_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_a_q, pend_a_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              to_q, to_d;
    logic [CNT_W-1:0]  sc_q, sc_d, bc_q, bc_d;

    logic              run_eval;   // evaluate the cycle with RUN rules
    logic              go;         // issue a redirect this cycle
    logic [ADDR_W-1:0] go_addr;
    logic              hz_frz;     // freeze caused by the hazard alone

    always_comb begin
        freeze_o         = 1'b0;
        branch_taken_o   = 1'b0;
        branch_address_o = '0;
        flush_o          = 1'b0;
        stall_all_o      = 1'b0;
        state_d          = state_q;
        pend_v_d         = pend_v_q;
        pend_a_d         = pend_a_q;
        fcnt_d           = fcnt_q;
        run_eval         = 1'b0;
        go               = 1'b0;
        go_addr          = '0;
        hz_frz           = 1'b0;

        case (state_q)
            MEM_WAIT: begin
                if (mem_busy_i) begin
                    freeze_o    = 1'b1;
                    stall_all_o = 1'b1;
                    if (exe_branch_req_i) begin
                        pend_v_d = 1'b1;
                        pend_a_d = exe_branch_addr_i;
                    end
                end else if (pend_v_q) begin
                    go       = 1'b1;
                    go_addr  = pend_a_q;
                    pend_v_d = 1'b0;
                end else begin
                    run_eval = 1'b1;
                end
            end
            REDIRECT: begin
                if (mem_busy_i) begin
                    // Hold the flush window; keep any branch for when memory frees up.
                    freeze_o    = 1'b1;
                    stall_all_o = 1'b1;
                    if (exe_branch_req_i) begin
                        pend_v_d = 1'b1;
                        pend_a_d = exe_branch_addr_i;
                    end
                end else if (exe_branch_req_i) begin
                    go       = 1'b1;
                    go_addr  = exe_branch_addr_i;
                    pend_v_d = 1'b0;
                end else if (pend_v_q) begin
                    go       = 1'b1;
                    go_addr  = pend_a_q;
                    pend_v_d = 1'b0;
                end else begin
                    flush_o = 1'b1;
                    fcnt_d  = fcnt_q - 4'd1;
                    if (fcnt_q <= 4'd1) begin
                        state_d = RUN;
                        fcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d  = RUN;
                run_eval = 1'b1;
            end
        endcase

        if (run_eval) begin
            if (mem_busy_i) begin
                freeze_o    = 1'b1;
                stall_all_o = 1'b1;
                state_d     = MEM_WAIT;
                if (exe_branch_req_i) begin
                    pend_v_d = 1'b1;
                    pend_a_d = exe_branch_addr_i;
                end
            end else if (exe_branch_req_i) begin
                go      = 1'b1;
                go_addr = exe_branch_addr_i;
            end else begin
                freeze_o = hazard_detected_i;
                hz_frz   = hazard_detected_i;
            end
        end

        if (go) begin
            branch_taken_o   = 1'b1;
            flush_o          = 1'b1;
            branch_address_o = go_addr;
            state_d          = (FLUSH_CYCLES == 0) ? RUN : REDIRECT;
            fcnt_d           = FLUSH_LD;
        end

        if (rst_i) begin
            freeze_o         = 1'b0;
            branch_taken_o   = 1'b0;
            branch_address_o = '0;
            flush_o          = 1'b0;
            stall_all_o      = 1'b0;
            hz_frz           = 1'b0;
        end
    end

    always_comb begin
        wd_d = '0;
        to_d = to_q;
        sc_d = sc_q;
        bc_d = bc_q;
        if (hz_frz) begin
            wd_d = wd_q;
            if (wd_q != WD_W'(STALL_LIMIT)) wd_d = wd_q + WD_W'(1);
            if (wd_q >= WD_W'(STALL_LIMIT - 1)) to_d = 1'b1;
        end
        if (freeze_o && sc_q != '1) sc_d = sc_q + CNT_W'(1);
        if (branch_taken_o && bc_q != '1) bc_d = bc_q + CNT_W'(1);
        if (perf_clr_i) begin
            wd_d = '0;
            to_d = 1'b0;
            sc_d = '0;
            bc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            pend_v_q <= 1'b0;
            pend_a_q <= '0;
            fcnt_q   <= '0;
            wd_q     <= '0;
            to_q     <= 1'b0;
            sc_q     <= '0;
            bc_q     <= '0;
        end else begin
            state_q  <= state_d;
            pend_v_q <= pend_v_d;
            pend_a_q <= pend_a_d;
            fcnt_q   <= fcnt_d;
            wd_q     <= wd_d;
            to_q     <= to_d;
            sc_q     <= sc_d;
            bc_q     <= bc_d;
        end
    end

    assign state_o         = state_q;
    assign stall_count_o   = sc_q;
    assign branch_count_o  = bc_q;
    assign stall_timeout_o = to_q;

endmodule
